// File: rtl/fpu_cvt_to_int_seq.sv
// fpu_cvt_to_int_seq: multi-cycle FCVT.W.S / FCVT.WU.S sequencer.
// Four-state FSM (IDLE -> ALIGN -> ROUND -> DONE): it latches and classifies
// the operand, aligns it to an integer part plus guard/round/sticky bits,
// rounds and range-checks it, then holds the result until the consumer
// accepts it.
module fpu_cvt_to_int_seq #(
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      op_a_i,
  input  logic             is_unsigned_i,
  input  logic [2:0]       rm_i,
  input  logic [2:0]       frm_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      result_o,
  output logic [4:0]       fflags_o,
  output logic             illegal_rm_o,
  output logic [TAG_W-1:0] tag_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Round-increment decision from LSB, guard, round, sticky and sign.
  function automatic logic rnd_inc(input logic [2:0] rm, input logic sign,
                                   input logic l, input logic g,
                                   input logic r, input logic s);
    logic inc;
    case (rm)
      3'b000:  inc = g & (r | s | l);       // RNE
      3'b001:  inc = 1'b0;                  // RTZ
      3'b010:  inc = sign & (g | r | s);    // RDN
      3'b011:  inc = ~sign & (g | r | s);   // RUP
      3'b100:  inc = g;                     // RMM
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        op_q, op_d;
  logic               uns_q, uns_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [2:0]         rm_q, rm_d;
  logic               nan_q, nan_d;
  logic               inf_q, inf_d;
  logic [31:0]        int_q, int_d;
  logic               g_q, g_d, r_q, r_d, s_q, s_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        result_q, result_d;
  logic [4:0]         fflags_q, fflags_d;
  logic               illegal_q, illegal_d;
  logic [TAG_W-1:0]   tag_out_q, tag_out_d;

  // Datapath helpers (pure combinational, consumed by the FSM below).
  logic               accept_s;
  logic [2:0]         rm_res_s;
  logic signed [9:0]  unb_exp_s;
  logic signed [9:0]  shamt_full_s;
  logic [5:0]         shamt_s;
  logic [23:0]        sig_s;
  logic [63:0]        wide_s;
  logic               inc_s;
  logic [32:0]        mag_s;
  logic               sign_s;
  logic               in_range_s;
  logic               rm_bad_s;

  assign accept_s     = in_valid_i & (state_q == IDLE) & ~flush_i;
  assign rm_res_s     = (rm_i == 3'b111) ? frm_i : rm_i;
  // Unbiased exponent kept in signed 10-bit so no 8-bit wraparound occurs.
  assign unb_exp_s    = $signed({2'b00, op_q[30:23]}) - 10'sd127;
  assign shamt_full_s = unb_exp_s + 10'sd9;
  assign shamt_s      = shamt_full_s[5:0];
  assign sig_s        = {|op_q[30:23], op_q[22:0]};
  // Fixed point: [63:32] integer part, [31:0] fraction.
  assign wide_s       = {40'd0, sig_s} << shamt_s;
  assign sign_s       = op_q[31];
  assign inc_s        = rnd_inc(rm_q, sign_s, int_q[0], g_q, r_q, s_q);
  assign mag_s        = {1'b0, int_q} + {32'd0, inc_s};
  assign rm_bad_s     = (rm_q == 3'b101) | (rm_q == 3'b110) | (rm_q == 3'b111);

  // Range check of the rounded magnitude against the target format.
  always_comb begin
    in_range_s = 1'b0;
    if (ovf_q | mag_s[32]) begin
      in_range_s = 1'b0;
    end else if (uns_q) begin
      in_range_s = ~sign_s | (mag_s[31:0] == 32'd0);
    end else if (sign_s) begin
      in_range_s = (mag_s[31:0] <= 32'h8000_0000);
    end else begin
      in_range_s = ~mag_s[31];
    end
  end

  // Next-state and datapath register updates for the sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    uns_d       = uns_q;
    tag_d       = tag_q;
    rm_d        = rm_q;
    nan_d       = nan_q;
    inf_d       = inf_q;
    int_d       = int_q;
    g_d         = g_q;
    r_d         = r_q;
    s_d         = s_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    fflags_d    = fflags_q;
    illegal_d   = illegal_q;
    tag_out_d   = tag_out_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d    = op_a_i;
          uns_d   = is_unsigned_i;
          tag_d   = tag_i;
          rm_d    = rm_res_s;
          nan_d   = (op_a_i[30:23] == 8'hFF) & (op_a_i[22:0] != 23'd0);
          inf_d   = (op_a_i[30:23] == 8'hFF) & (op_a_i[22:0] == 23'd0);
          state_d = ALIGN;
        end else begin
          state_d = IDLE;
        end
      end

      ALIGN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          if (unb_exp_s < -10'sd1) begin
            // Magnitude below one half: everything folds into sticky.
            int_d = 32'd0;
            g_d   = 1'b0;
            r_d   = 1'b0;
            s_d   = |sig_s;
            ovf_d = 1'b0;
          end else if (unb_exp_s > 10'sd31) begin
            int_d = 32'd0;
            g_d   = 1'b0;
            r_d   = 1'b0;
            s_d   = 1'b0;
            ovf_d = 1'b1;
          end else begin
            int_d = wide_s[63:32];
            g_d   = wide_s[31];
            r_d   = wide_s[30];
            s_d   = |wide_s[29:0];
            ovf_d = 1'b0;
          end
          state_d = ROUND;
        end
      end

      ROUND: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          illegal_d = 1'b0;
          if (rm_bad_s) begin
            result_d  = 32'd0;
            fflags_d  = 5'b00000;
            illegal_d = 1'b1;
          end else if (nan_q) begin
            result_d = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            fflags_d = 5'b10000;
          end else if (inf_q | ~in_range_s) begin
            if (sign_s) begin
              result_d = uns_q ? 32'h0000_0000 : 32'h8000_0000;
            end else begin
              result_d = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            end
            fflags_d = 5'b10000;
          end else begin
            result_d = sign_s ? (~mag_s[31:0] + 32'd1) : mag_s[31:0];
            fflags_d = {4'b0000, g_q | r_q | s_q};
          end
          tag_out_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (flush_i) begin
          out_valid_d = 1'b0;
          result_d    = 32'd0;
          fflags_d    = 5'b00000;
          illegal_d   = 1'b0;
          tag_out_d   = '0;
          state_d     = IDLE;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      op_q        <= 32'd0;
      uns_q       <= 1'b0;
      tag_q       <= '0;
      rm_q        <= 3'b000;
      nan_q       <= 1'b0;
      inf_q       <= 1'b0;
      int_q       <= 32'd0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      fflags_q    <= 5'b00000;
      illegal_q   <= 1'b0;
      tag_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      uns_q       <= uns_d;
      tag_q       <= tag_d;
      rm_q        <= rm_d;
      nan_q       <= nan_d;
      inf_q       <= inf_d;
      int_q       <= int_d;
      g_q         <= g_d;
      r_q         <= r_d;
      s_q         <= s_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      fflags_q    <= fflags_d;
      illegal_q   <= illegal_d;
      tag_out_q   <= tag_out_d;
    end
  end

  assign in_ready_o   = (state_q == IDLE);
  assign out_valid_o  = out_valid_q;
  assign result_o     = result_q;
  assign fflags_o     = fflags_q;
  assign illegal_rm_o = illegal_q;
  assign tag_o        = tag_out_q;

endmodule

// File: tb/tb_fpu_cvt_to_int_seq.sv
// Scoreboard bench for fpu_cvt_to_int_seq: directed and random conversions
// are checked against an arithmetic reference model.
module tb_fpu_cvt_to_int_seq;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      op_a_i;
  logic             is_unsigned_i;
  logic [2:0]       rm_i;
  logic [2:0]       frm_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      result_o;
  logic [4:0]       fflags_o;
  logic             illegal_rm_o;
  logic [TAG_W-1:0] tag_o;

  fpu_cvt_to_int_seq #(.TAG_W(TAG_W)) dut (
    .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_a_i(op_a_i), .is_unsigned_i(is_unsigned_i), .rm_i(rm_i), .frm_i(frm_i),
    .tag_i(tag_i), .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .fflags_o(fflags_o), .illegal_rm_o(illegal_rm_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      res;
    logic [4:0]       fl;
    logic             ill;
    logic [TAG_W-1:0] tag;
    logic [31:0]      acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bp_mode = 0;   // 0 always ready, 1 random, 2 held low

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact value sig*2^(e-23), rounded by comparing remainder to half.
  function automatic exp_t model(input logic [31:0] a, input logic uns,
                                 input logic [2:0] rm, input logic [2:0] frm);
    exp_t   e_r;
    logic [2:0] rmr;
    bit     neg, nan, inf, big, inexact, gt, eq, up, ok;
    int     ex, e, sh;
    longint sig, mag, rem, half;
    e_r = '0;
    rmr = (rm == 3'b111) ? frm : rm;
    neg = a[31];
    ex  = int'(a[30:23]);
    if (rmr >= 3'd5) begin
      e_r.ill = 1'b1;
      return e_r;
    end
    nan = (ex == 255) && (a[22:0] != 0);
    inf = (ex == 255) && (a[22:0] == 0);
    big = 0; inexact = 0; gt = 0; eq = 0; mag = 0;
    sig = (ex == 0) ? longint'(a[22:0]) : (longint'(a[22:0]) + 64'sd8388608);
    e   = (ex == 0) ? -126 : ex - 127;
    if (e >= 23) begin
      if (e > 40) big = 1;
      else mag = sig << (e - 23);
    end else begin
      sh = 23 - e;
      if (sh >= 40) begin
        mag = 0; inexact = (sig != 0);
      end else begin
        mag  = sig >> sh;
        rem  = sig - (mag << sh);
        half = 64'sd1 << (sh - 1);
        gt = rem > half; eq = rem == half; inexact = rem != 0;
      end
    end
    case (rmr)
      3'd0: up = gt || (eq && mag[0]);
      3'd1: up = 0;
      3'd2: up = neg && inexact;
      3'd3: up = !neg && inexact;
      default: up = gt || eq;
    endcase
    if (up) mag = mag + 1;
    if (uns) ok = !big && mag <= 64'sd4294967295 && (!neg || mag == 0);
    else if (neg) ok = !big && mag <= 64'sd2147483648;
    else ok = !big && mag <= 64'sd2147483647;
    if (nan || inf || !ok) begin
      e_r.fl = 5'b10000;
      if (nan || !neg) e_r.res = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      else e_r.res = uns ? 32'h0 : 32'h8000_0000;
    end else begin
      e_r.res = neg ? 32'(-mag) : 32'(mag);
      e_r.fl  = inexact ? 5'b00001 : 5'b00000;
    end
    return e_r;
  endfunction

  // Backpressure driver: updates out_ready just after each rising edge.
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode == 0) out_ready_i = 1'b1;
      else if (bp_mode == 1) out_ready_i = ($urandom % 3) != 0;
      else out_ready_i = 1'b0;
    end
  end

  // Monitor: compares every presented result against the scoreboard head.
  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!reset_i && out_valid_o) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid result=%h flags=%b", result_o, fflags_o);
        end else begin
          e = q[0];
          if (!seen) begin
            checks++;
            if (cyc - int'(e.acc) != 3) begin
              errors++;
              $display("FAIL latency got=%0d exp=3", cyc - int'(e.acc));
            end
            seen = 1;
          end
          checks++;
          if ({result_o, fflags_o, illegal_rm_o, tag_o} !== {e.res, e.fl, e.ill, e.tag}) begin
            errors++;
            $display("FAIL result got res=%h fl=%b ill=%b tag=%h exp res=%h fl=%b ill=%b tag=%h",
                     result_o, fflags_o, illegal_rm_o, tag_o, e.res, e.fl, e.ill, e.tag);
          end
          checks++;
          if (in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready got=%b exp=0", in_ready_o);
          end
          if (out_ready_i) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic uns, input logic [2:0] rm,
                       input logic [2:0] frm, input bit expect_out);
    int   n;
    exp_t e;
    @(negedge clk);
    op_a_i = a; is_unsigned_i = uns; rm_i = rm; frm_i = frm;
    tag_i = TAG_W'($urandom);
    in_valid_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout got=busy exp=ready");
    end else if (expect_out) begin
      e = model(a, uns, rm, frm);
      e.tag = tag_i;
      e.acc = 32'(cyc);
      q.push_back(e);
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk); n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0", q.size());
      q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic        uns;
    logic [2:0]  rm;
    logic [2:0]  frm;
  } vec_t;

  vec_t dir[$];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic [31:0] a;
    reset_i = 1'b1; in_valid_i = 1'b0; op_a_i = 32'd0; is_unsigned_i = 1'b0;
    rm_i = 3'b000; frm_i = 3'b000; tag_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, out_valid_o, result_o, fflags_o, illegal_rm_o},
        {26'd0, 1'b0, 32'd0, 5'd0, 1'b0});
    chk("reset_tag", 64'(tag_o), 64'd0);
    chk("reset_ready", 64'(in_ready_o), 64'd1);
    reset_i = 1'b0;

    dir.push_back({32'h4020_0000, 1'b0, 3'b000, 3'b000});
    dir.push_back({32'h4020_0000, 1'b0, 3'b100, 3'b000});
    dir.push_back({32'h4020_0000, 1'b0, 3'b111, 3'b011});
    dir.push_back({32'hBFC0_0000, 1'b0, 3'b010, 3'b000});
    dir.push_back({32'hBE80_0000, 1'b1, 3'b001, 3'b000});
    dir.push_back({32'hBF80_0000, 1'b1, 3'b000, 3'b000});
    dir.push_back({32'hCF00_0000, 1'b0, 3'b000, 3'b000});
    dir.push_back({32'h4F00_0000, 1'b0, 3'b000, 3'b000});
    dir.push_back({32'h4F32_D05E, 1'b1, 3'b000, 3'b000});
    dir.push_back({32'h4F80_0000, 1'b1, 3'b000, 3'b000});
    dir.push_back({32'h7FC0_0000, 1'b0, 3'b000, 3'b000});
    dir.push_back({32'hFF80_0000, 1'b0, 3'b000, 3'b000});
    dir.push_back({32'h8000_0000, 1'b0, 3'b000, 3'b000});
    dir.push_back({32'h4020_0000, 1'b0, 3'b111, 3'b101});
    foreach (dir[i]) issue(dir[i].a, dir[i].uns, dir[i].rm, dir[i].frm, 1'b1);
    drain();

    // Backpressure: result held for several cycles.
    bp_mode = 2;
    issue(32'h4049_0FDB, 1'b0, 3'b000, 3'b000, 1'b1);
    n = 0;
    while (!out_valid_o && n < 20) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    chk("hold_valid", 64'(out_valid_o), 64'd1);
    bp_mode = 0;
    drain();

    // Flush in ROUND: nothing presented, IDLE on the next cycle.
    issue(32'h4020_0000, 1'b0, 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_idle", {62'd0, in_ready_o, out_valid_o}, {62'd0, 1'b1, 1'b0});
    repeat (4) @(negedge clk);
    chk("flush_no_valid", 64'(out_valid_o), 64'd0);

    // Reset in ALIGN after a result is held on the outputs.
    issue(32'hC2F6_0000, 1'b0, 3'b000, 3'b000, 1'b1);
    drain();
    issue(32'h4020_0000, 1'b0, 3'b000, 3'b000, 1'b0);
    reset_i = 1'b1;
    #1;
    chk("rst_mid_outputs", {26'd0, out_valid_o, result_o, fflags_o, illegal_rm_o},
        {26'd0, 1'b0, 32'd0, 5'd0, 1'b0});
    chk("rst_mid_tag", 64'(tag_o), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 64'(in_ready_o), 64'd1);

    // Random conversions with random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      a[31]    = 1'($urandom);
      a[30:23] = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom_range(100, 162));
      a[22:0]  = (($urandom % 8) == 0) ? 23'd0 : 23'($urandom);
      issue(a, 1'($urandom), 3'($urandom), 3'($urandom), 1'b1);
    end
    drain();
    bp_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_cvt_to_int_seq.md
Name: fpu_cvt_to_int_seq

Overview:
Multi-cycle sequencer for FCVT.W.S / FCVT.WU.S in the FPU arithmetic path. It accepts one conversion request at a time over a valid/ready handshake and resolves the dynamic rounding mode from frm. It unpacks and classifies the single-precision operand, then aligns, rounds and range-checks it over fixed pipeline states. It returns the 32-bit integer result with RISC-V exception flags (NV, NX) and an illegal-rounding-mode indication to the FPU writeback stage.

Parameters:
TAG_W, 5, width of the opaque request tag (destination register index) passed through with the result.

Ports:
clk_i  input  1  clock
reset_i  input  1  asynchronous active-high reset
in_valid_i  input  1  request valid
in_ready_o  output  1  sequencer can accept a request
op_a_i  input  32  IEEE-754 single-precision source operand
is_unsigned_i  input  1  1 = FCVT.WU.S, 0 = FCVT.W.S
rm_i  input  3  instruction rounding-mode field
frm_i  input  3  fcsr.frm, used only when rm_i = 3'b111
tag_i  input  TAG_W  request tag
flush_i  input  1  abort the in-flight operation (pipeline kill)
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
result_o  output  32  integer result
fflags_o  output  5  {NV,DZ,OF,UF,NX}; only NV (bit 4) and NX (bit 0) are ever set
illegal_rm_o  output  1  resolved rounding mode is reserved
tag_o  output  TAG_W  tag of the result

Behaviour:
- FSM states: IDLE, ALIGN, ROUND, DONE. Reset drives IDLE, out_valid_o=0, result_o=0, fflags_o=0, illegal_rm_o=0, tag_o=0.
- in_ready_o = (state==IDLE). A request is accepted when in_valid_i && in_ready_o. On acceptance the block:
  - latches the operand, is_unsigned_i and tag_i;
  - resolves rm as (rm_i==3'b111) ? frm_i : rm_i;
  - classifies the operand: NaN (exp=FF, frac!=0), Inf, zero/subnormal (exp=0, treated as magnitude <1 with sticky=|frac);
  - moves to ALIGN.
- ALIGN, one cycle:
  - forms the 24-bit significand with the hidden bit and shifts it to a 32-bit integer part plus guard, round and sticky bits;
  - the unbiased exponent is computed in signed 10-bit arithmetic; no 8-bit wraparound is permitted;
  - if the exponent is < -1, the integer part is 0, G=R=0 and S=|significand;
  - if the exponent is > 31, an overflow flag is pre-set.
  - Next state is ROUND.
- ROUND, one cycle:
  - the increment is chosen from L, G, R, S and the sign:
    - RNE: G&(R|S|L);
    - RTZ: 0;
    - RDN: sign&(G|R|S);
    - RUP: ~sign&(G|R|S);
    - RMM: G.
  - The magnitude is added in 33 bits so that a carry-out is detected.
  - Range check, on the rounded magnitude M:
    - signed: positive valid when M<=2^31-1; negative valid when M<=2^31;
    - unsigned: valid when M<=2^32-1 and (positive or M==0).
  - Next state is DONE.
- Results:
  - Valid range: result is ±M (two's complement for signed negative). NX = G|R|S. NV = 0.
  - NaN: 0x7FFFFFFF signed, 0xFFFFFFFF unsigned. NV=1, NX=0.
  - +Inf or positive out-of-range: 0x7FFFFFFF signed, 0xFFFFFFFF unsigned. NV=1, NX=0.
  - -Inf or negative out-of-range: 0x80000000 signed, 0x00000000 unsigned. NV=1, NX=0.
  - Zero (±0): 0, no flags.
- Reserved resolved rm (101, 110, 111): result 0, fflags 0, illegal_rm_o=1. The operation still completes with the same latency.
- DONE: out_valid_o=1 and all outputs are held stable until out_ready_i. On the handshake the block returns to IDLE. There is no back-to-back acceptance in the handshake cycle (in_ready_o rises the next cycle).
- Latency: acceptance cycle N gives out_valid_o=1 at N+3 with no backpressure. Throughput is 1 request per 4 cycles.
- flush_i:
  - in ALIGN, ROUND or DONE, the state goes to IDLE on the next edge and out_valid_o drops; the result is discarded and no flags are reported;
  - flush_i in IDLE with in_valid_i high: the request is not accepted (flush has priority).
- reset_i mid-operation: the block returns immediately to IDLE with outputs at reset values; no partial result is ever presented.
- in_valid_i while busy is ignored (in_ready_o=0); the requester must hold the request.

Test Plan:
- 0x40200000 (2.5), signed:
  - rm=000 gives 0x00000002 with NX;
  - rm=100 gives 0x00000003 with NX;
  - rm=111 with frm=011 gives 0x00000003 with NX;
  - out_valid_o is observed exactly 3 cycles after acceptance.
- Sign handling and unsigned edges:
  - 0xBFC00000 (-1.5) signed, rm=010 gives 0xFFFFFFFE with NX;
  - -0.25 (0xBE800000) unsigned, rm=001 gives 0 with NX only;
  - -1.0 (0xBF800000) unsigned gives 0 with NV.
- Boundaries:
  - 0xCF000000 (-2^31) signed gives 0x80000000 with no flags;
  - 0x4F000000 (2^31) signed gives 0x7FFFFFFF with NV;
  - 0x4F32D05E unsigned gives 0xB2D05E00 with no flags;
  - 0x4F800000 (2^32) unsigned gives 0xFFFFFFFF with NV.
- Specials:
  - 0x7FC00000 signed gives 0x7FFFFFFF with NV;
  - 0xFF800000 signed gives 0x80000000 with NV;
  - 0x80000000 gives 0 with no flags.
- Reserved rounding mode: rm=111 with frm=101 gives illegal_rm_o=1, result 0, flags 0.
- Handshake:
  - out_ready_i held low 5 cycles: result, flags and tag stay stable, and in_ready_o stays 0;
  - flush_i asserted in ROUND: no out_valid_o, and the block is back in IDLE next cycle;
  - reset_i asserted in ALIGN: all outputs at reset values and in_ready_o=1 after release.
